majority_voter_pipe: RTL

Parametrised, pipelined N-input majority voter with a persistence filter and valid/ready streaming handshake. Each accepted N-bit sample gets a raw majority decision and a filtered decision. The filtered decision changes only after the new value persists for HOLD consecutive samples. Sits between redundant sensor/channel sources and downstream control logic, generalising the fixed 5-input combinational voter.

---
 rtl/maj_pkg.sv | 18 +
 rtl/maj_popcount.sv | 20 ++
 rtl/majority_voter_pipe.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/maj_pkg.sv
// Shared types and elaboration helpers for the majority voter family.
package maj_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } filt_state_e;

  function automatic int pop_w(input int n);
    return $clog2(n + 1);
  endfunction

  // A majority is only well defined for an odd channel count of at least three.
  function automatic bit n_ok(input int n);
    return (n >= 3) && ((n % 2) == 1);
  endfunction

endpackage

// File: rtl/maj_popcount.sv
// Combinational N-bit population count.
module maj_popcount
  import maj_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]          data,
  output logic [pop_w(N)-1:0]   count
);

  localparam int PW = pop_w(N);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      count = count + PW'(data[i]);
    end
  end

endmodule

// File: rtl/majority_voter_pipe.sv
// Two-stage pipelined N-input majority voter with persistence filter and valid/ready handshake.
// Build option: MAJ_VOTER_STATS_EN enables the ones/disagree_cnt statistics outputs.
module majority_voter_pipe
  import maj_pkg::*;
#(
  parameter int N     = 5,
  parameter int HOLD  = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  z,
  output logic                  z_raw,
  output logic                  unanimous,
  output logic [pop_w(N)-1:0]   ones,
  output logic [CNT_W-1:0]      disagree_cnt,
  input  logic                  stats_clr
);

  localparam int PW = pop_w(N);
  localparam int RW = $clog2(HOLD + 1);

  if (!n_ok(N)) begin : g_bad_n
    $error("majority_voter_pipe: N must be odd and >= 3");
  end
  if (HOLD < 1) begin : g_bad_hold
    $error("majority_voter_pipe: HOLD must be >= 1");
  end

  logic          en;
  logic [PW-1:0] pop;
  logic          s1_valid;
  logic [PW-1:0] s1_pop;
  logic          s1_unan;
  logic          m;

  filt_state_e   state, state_nxt;
  logic [RW-1:0] run_cnt, run_nxt, run_inc;
  logic          z_nxt;

  // Whole pipeline advances together; it stalls only when a beat is held for downstream.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  maj_popcount #(.N(N)) u_pop (
    .data  (in_data),
    .count (pop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pop   <= '0;
      s1_unan  <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pop  <= pop;
        s1_unan <= (pop == '0) || (pop == PW'(N));
      end
    end
  end

  assign m       = s1_pop > PW'(N / 2);
  assign run_inc = run_cnt + RW'(1);

  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    z_nxt     = z;
    case (state)
      STABLE: begin
        if (m != z) begin
          if (HOLD == 1) begin
            z_nxt = m;
          end else begin
            state_nxt = PENDING;
            run_nxt   = RW'(1);
          end
        end
      end
      PENDING: begin
        if (m != z) begin
          if (run_inc == RW'(HOLD)) begin
            z_nxt     = m;
            run_nxt   = '0;
            state_nxt = STABLE;
          end else begin
            run_nxt = run_inc;
          end
        end else begin
          state_nxt = STABLE;
          run_nxt   = '0;
        end
      end
      default: begin
        state_nxt = STABLE;
        run_nxt   = '0;
      end
    endcase
  end

  // Filter state moves only on real samples, so bubbles neither advance nor reset it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      z_raw     <= 1'b0;
      unanimous <= 1'b0;
      z         <= 1'b0;
      state     <= STABLE;
      run_cnt   <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        z_raw     <= m;
        unanimous <= s1_unan;
        z         <= z_nxt;
        state     <= state_nxt;
        run_cnt   <= run_nxt;
      end
    end
  end

`ifdef MAJ_VOTER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones         <= '0;
      disagree_cnt <= '0;
    end else begin
      if (en && s1_valid) begin
        ones <= s1_pop;
      end
      if (stats_clr) begin
        disagree_cnt <= '0;
      end else if (en && s1_valid && !s1_unan && (disagree_cnt != '1)) begin
        disagree_cnt <= disagree_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign ones             = '0;
  assign disagree_cnt     = '0;
`endif

endmodule
